// File: rtl/alu_bist_ctrl.sv
// rtl/alu_bist_ctrl.sv - BIST initiator that sweeps all 16 ALU opcodes and checks results against a golden model
module alu_bist_ctrl #(
   parameter int WIDTH   = 16,
   parameter int ALU_LAT = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A_SEED,
   input  logic [WIDTH-1:0] B_SEED,
   output logic [WIDTH-1:0] ALU_A,
   output logic [WIDTH-1:0] ALU_B,
   output logic [3:0]       ALU_FUN,
   input  logic [WIDTH-1:0] ALU_OUT,
   input  logic             Arith_Flag,
   input  logic             Logic_Flag,
   input  logic             CMP_Flag,
   input  logic             Shift_Flag,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [4:0]       FAIL_CNT,
   output logic [3:0]       FIRST_FAIL_FUN
);

   localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [CW-1:0] LAT_M1 = CW'(ALU_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_WAIT  = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_wait;
   logic [WIDTH-1:0] r_seed_a;
   logic [WIDTH-1:0] r_seed_b;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [3:0]       r_alu_fun;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [4:0]       r_fail_cnt;
   logic [3:0]       r_first_fail;

   logic [WIDTH-1:0] w_exp_res;
   logic [3:0]       w_exp_flg;
   logic [3:0]       w_act_flg;
   logic             w_mismatch;
   logic [3:0]       w_fun_nxt;
   logic [WIDTH-1:0] w_b_nxt;

   // Golden model evaluated on the operands currently held on the ALU inputs.
   always_comb begin
      w_exp_res = '0;
      w_exp_flg = 4'b0000;
      unique case (r_alu_fun)
         4'h0: begin w_exp_res = r_alu_a + r_alu_b;     w_exp_flg = 4'b1000; end
         4'h1: begin w_exp_res = r_alu_a - r_alu_b;     w_exp_flg = 4'b1000; end
         4'h2: begin w_exp_res = r_alu_a * r_alu_b;     w_exp_flg = 4'b1000; end
         4'h3: begin w_exp_res = r_alu_a / r_alu_b;     w_exp_flg = 4'b1000; end
         4'h4: begin w_exp_res = r_alu_a & r_alu_b;     w_exp_flg = 4'b0100; end
         4'h5: begin w_exp_res = r_alu_a | r_alu_b;     w_exp_flg = 4'b0100; end
         4'h6: begin w_exp_res = ~(r_alu_a & r_alu_b);  w_exp_flg = 4'b0100; end
         4'h7: begin w_exp_res = ~(r_alu_a | r_alu_b);  w_exp_flg = 4'b0100; end
         4'h8: begin w_exp_res = r_alu_a ^ r_alu_b;     w_exp_flg = 4'b0100; end
         4'h9: begin w_exp_res = ~(r_alu_a ^ r_alu_b);  w_exp_flg = 4'b0100; end
         4'hA: begin
            w_exp_res = (r_alu_a == r_alu_b) ? WIDTH'(1) : '0;
            w_exp_flg = 4'b0010;
         end
         4'hB: begin
            w_exp_res = (r_alu_a > r_alu_b) ? WIDTH'(2) : '0;
            w_exp_flg = 4'b0010;
         end
         4'hC: begin
            w_exp_res = (r_alu_a < r_alu_b) ? WIDTH'(3) : '0;
            w_exp_flg = 4'b0010;
         end
         4'hD: begin w_exp_res = r_alu_a >> 1;          w_exp_flg = 4'b0001; end
         4'hE: begin w_exp_res = r_alu_a << 1;          w_exp_flg = 4'b0001; end
         default: begin
            w_exp_res = '0;
            w_exp_flg = 4'b0000;
         end
      endcase
   end

   assign w_act_flg  = {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag};
   assign w_mismatch = (ALU_OUT != w_exp_res) || (w_act_flg != w_exp_flg);
   assign w_fun_nxt  = r_alu_fun + 4'd1;
   // Divide by zero is avoided by substituting 1 for the divisor on the DIV opcode only.
   assign w_b_nxt    = ((w_fun_nxt == 4'h3) && (r_seed_b == '0)) ? WIDTH'(1) : r_seed_b;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state      <= S_IDLE;
         r_wait       <= '0;
         r_seed_a     <= '0;
         r_seed_b     <= '0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_fun    <= 4'hF;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_fail_cnt   <= '0;
         r_first_fail <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               r_alu_fun <= 4'hF;
               if (START) begin
                  r_seed_a     <= A_SEED;
                  r_seed_b     <= B_SEED;
                  r_alu_a      <= A_SEED;
                  r_alu_b      <= B_SEED;
                  r_alu_fun    <= 4'h0;
                  r_fail_cnt   <= '0;
                  r_first_fail <= '0;
                  r_pass       <= 1'b0;
                  r_busy       <= 1'b1;
                  r_state      <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               r_wait  <= LAT_M1;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_wait == '0) begin
                  if (w_mismatch) begin
                     r_fail_cnt <= r_fail_cnt + 5'd1;
                     if (r_fail_cnt == '0) begin
                        r_first_fail <= r_alu_fun;
                     end
                  end
                  if (r_alu_fun == 4'hF) begin
                     r_state <= S_FIN;
                  end else begin
                     r_alu_fun <= w_fun_nxt;
                     r_alu_a   <= r_seed_a;
                     r_alu_b   <= w_b_nxt;
                     r_state   <= S_DRIVE;
                  end
               end else begin
                  r_wait <= r_wait - 1'b1;
               end
            end
            S_FIN: begin
               r_done    <= 1'b1;
               r_busy    <= 1'b0;
               r_pass    <= (r_fail_cnt == '0);
               r_alu_fun <= 4'hF;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ALU_A          = r_alu_a;
   assign ALU_B          = r_alu_b;
   assign ALU_FUN        = r_alu_fun;
   assign BUSY           = r_busy;
   assign DONE           = r_done;
   assign PASS           = r_pass;
   assign FAIL_CNT       = r_fail_cnt;
   assign FIRST_FAIL_FUN = r_first_fail;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// tb/tb_alu_bist_ctrl.sv - self-checking bench for alu_bist_ctrl with 1- and 2-stage ALU models
module tb_alu_bist_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        START;
   logic [15:0] A_SEED;
   logic [15:0] B_SEED;

   logic [15:0] d1_a, d1_b, a1_out;
   logic [3:0]  d1_fun, a1_flg, d1_first;
   logic        d1_busy, d1_done, d1_pass;
   logic [4:0]  d1_cnt;

   logic [15:0] d2_a, d2_b, a2_out, a2_s1;
   logic [3:0]  d2_fun, a2_flg, d2_first, f2_s1;
   logic        d2_busy, d2_done, d2_pass;
   logic [4:0]  d2_cnt;

   logic [15:0] res_x [16];
   logic [3:0]  flg_x [16];

   int checks = 0;
   int passes = 0;

   always #5 CLK = ~CLK;

   alu_bist_ctrl #(.WIDTH(16), .ALU_LAT(1)) dut1 (
      .CLK(CLK), .RST(RST), .START(START), .A_SEED(A_SEED), .B_SEED(B_SEED),
      .ALU_A(d1_a), .ALU_B(d1_b), .ALU_FUN(d1_fun), .ALU_OUT(a1_out),
      .Arith_Flag(a1_flg[3]), .Logic_Flag(a1_flg[2]), .CMP_Flag(a1_flg[1]), .Shift_Flag(a1_flg[0]),
      .BUSY(d1_busy), .DONE(d1_done), .PASS(d1_pass), .FAIL_CNT(d1_cnt), .FIRST_FAIL_FUN(d1_first)
   );

   alu_bist_ctrl #(.WIDTH(16), .ALU_LAT(2)) dut2 (
      .CLK(CLK), .RST(RST), .START(START), .A_SEED(A_SEED), .B_SEED(B_SEED),
      .ALU_A(d2_a), .ALU_B(d2_b), .ALU_FUN(d2_fun), .ALU_OUT(a2_out),
      .Arith_Flag(a2_flg[3]), .Logic_Flag(a2_flg[2]), .CMP_Flag(a2_flg[1]), .Shift_Flag(a2_flg[0]),
      .BUSY(d2_busy), .DONE(d2_done), .PASS(d2_pass), .FAIL_CNT(d2_cnt), .FIRST_FAIL_FUN(d2_first)
   );

   function automatic logic [15:0] gold_res(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      int unsigned ua = a;
      int unsigned ub = b;
      case (op)
         4'd0:  return 16'(ua + ub);
         4'd1:  return 16'(ua - ub);
         4'd2:  return 16'(ua * ub);
         4'd3:  return (ub == 0) ? a : 16'(ua / ub);
         4'd4:  return a & b;
         4'd5:  return a | b;
         4'd6:  return ~(a & b);
         4'd7:  return ~(a | b);
         4'd8:  return a ^ b;
         4'd9:  return ~(a ^ b);
         4'd10: return (ua == ub) ? 16'd1 : 16'd0;
         4'd11: return (ua > ub)  ? 16'd2 : 16'd0;
         4'd12: return (ua < ub)  ? 16'd3 : 16'd0;
         4'd13: return 16'(ua / 2);
         4'd14: return 16'(ua * 2);
         default: return 16'd0;
      endcase
   endfunction

   function automatic logic [3:0] gold_flg(input logic [3:0] op);
      if (op <= 4'd3)  return 4'b1000;
      if (op <= 4'd9)  return 4'b0100;
      if (op <= 4'd12) return 4'b0010;
      if (op <= 4'd14) return 4'b0001;
      return 4'b0000;
   endfunction

   // ALU models with per-opcode fault injection (xor masks on result and flags).
   always @(posedge CLK) begin
      a1_out <= gold_res(d1_fun, d1_a, d1_b) ^ res_x[d1_fun];
      a1_flg <= gold_flg(d1_fun) ^ flg_x[d1_fun];
      a2_s1  <= gold_res(d2_fun, d2_a, d2_b) ^ res_x[d2_fun];
      f2_s1  <= gold_flg(d2_fun) ^ flg_x[d2_fun];
      a2_out <= a2_s1;
      a2_flg <= f2_s1;
   end

   task automatic clear_faults();
      for (int i = 0; i < 16; i++) begin
         res_x[i] = 16'd0;
         flg_x[i] = 4'd0;
      end
   endtask

   task automatic expect_result(output int n, output logic [3:0] first);
      n = 0;
      first = 4'd0;
      for (int op = 0; op < 16; op++) begin
         if (res_x[op] != 16'd0 || flg_x[op] != 4'd0) begin
            if (n == 0) first = 4'(op);
            n++;
         end
      end
   endtask

   task automatic do_run(input logic [15:0] a, input logic [15:0] b, input int mid_start);
      int          n_exp;
      logic [3:0]  first_exp;
      int          op1, op2;
      logic [15:0] b1_exp;
      expect_result(n_exp, first_exp);
      @(negedge CLK);
      A_SEED = a;
      B_SEED = b;
      START  = 1'b1;
      @(posedge CLK);
      #1;
      START  = 1'b0;
      A_SEED = 16'($urandom);
      B_SEED = 16'($urandom);
      for (int e = 0; e <= 52; e++) begin
         @(negedge CLK);
         START = (e == mid_start);
         op1 = (e / 2 > 15) ? 15 : e / 2;
         op2 = (e / 3 > 15) ? 15 : e / 3;
         b1_exp = (op1 == 3 && b == 16'd0) ? 16'd1 : b;
         checks++;
         if (d1_fun !== 4'(op1)) $display("FAIL fun1 e=%0d got %0d want %0d", e, d1_fun, op1);
         else passes++;
         checks++;
         if (d2_fun !== 4'(op2)) $display("FAIL fun2 e=%0d got %0d want %0d", e, d2_fun, op2);
         else passes++;
         if (e <= 33) begin
            checks++;
            if (d1_a !== a || d1_b !== b1_exp)
               $display("FAIL operands e=%0d got %h/%h want %h/%h", e, d1_a, d1_b, a, b1_exp);
            else passes++;
         end
         checks++;
         if (d1_done !== (e == 33) || d1_busy !== (e < 33))
            $display("FAIL done_busy1 e=%0d got %b%b want %b%b", e, d1_done, d1_busy, e == 33, e < 33);
         else passes++;
         checks++;
         if (d2_done !== (e == 49) || d2_busy !== (e < 49))
            $display("FAIL done_busy2 e=%0d got %b%b want %b%b", e, d2_done, d2_busy, e == 49, e < 49);
         else passes++;
      end
      START = 1'b0;
      checks++;
      if (d1_cnt !== 5'(n_exp) || d1_first !== first_exp || d1_pass !== (n_exp == 0))
         $display("FAIL result1 got cnt=%0d first=%0d pass=%b want cnt=%0d first=%0d pass=%b",
                  d1_cnt, d1_first, d1_pass, n_exp, first_exp, n_exp == 0);
      else passes++;
      checks++;
      if (d2_cnt !== 5'(n_exp) || d2_first !== first_exp || d2_pass !== (n_exp == 0))
         $display("FAIL result2 got cnt=%0d first=%0d pass=%b want cnt=%0d first=%0d pass=%b",
                  d2_cnt, d2_first, d2_pass, n_exp, first_exp, n_exp == 0);
      else passes++;
   endtask

   task automatic test_reset();
      RST   = 1'b1;
      START = 1'b0;
      A_SEED = 16'd0;
      B_SEED = 16'd0;
      clear_faults();
      #2 RST = 1'b0;
      #20;
      checks++;
      if (d1_a !== 16'd0 || d1_b !== 16'd0 || d1_fun !== 4'hF || d2_fun !== 4'hF)
         $display("FAIL reset_alu got %h %h %h %h want 0 0 f f", d1_a, d1_b, d1_fun, d2_fun);
      else passes++;
      checks++;
      if ({d1_busy, d1_done, d1_pass, d1_cnt, d1_first} !== 12'd0)
         $display("FAIL reset_status got %b want 0", {d1_busy, d1_done, d1_pass, d1_cnt, d1_first});
      else passes++;
      @(negedge CLK);
      RST = 1'b1;
   endtask

   task automatic test_basic();
      clear_faults();
      do_run(16'd6, 16'd2, -1);
   endtask

   task automatic test_mul_fault();
      clear_faults();
      res_x[2] = 16'd12 ^ 16'd13;
      do_run(16'd6, 16'd2, -1);
   endtask

   task automatic test_flag_fault();
      clear_faults();
      flg_x[11] = 4'b0010;
      flg_x[14] = 4'b0001;
      do_run(16'd6, 16'd2, -1);
   endtask

   task automatic test_div_zero();
      clear_faults();
      do_run(16'd9, 16'd0, -1);
   endtask

   task automatic test_mid_reset();
      clear_faults();
      res_x[0] = 16'h0001;
      @(negedge CLK);
      A_SEED = 16'd6;
      B_SEED = 16'd2;
      START  = 1'b1;
      @(posedge CLK);
      #1 START = 1'b0;
      for (int e = 0; e < 10; e++) @(negedge CLK);
      checks++;
      if (d1_cnt !== 5'd1 || d1_busy !== 1'b1)
         $display("FAIL pre_reset got cnt=%0d busy=%b want 1 1", d1_cnt, d1_busy);
      else passes++;
      RST = 1'b0;
      #1;
      checks++;
      if (d1_busy !== 1'b0 || d1_fun !== 4'hF || d1_cnt !== 5'd0 || d2_busy !== 1'b0)
         $display("FAIL mid_reset got busy=%b fun=%h cnt=%0d busy2=%b want 0 f 0 0",
                  d1_busy, d1_fun, d1_cnt, d2_busy);
      else passes++;
      @(negedge CLK);
      RST = 1'b1;
      clear_faults();
      do_run(16'd6, 16'd2, 7);
   endtask

   task automatic test_back_to_back();
      int op1;
      clear_faults();
      @(negedge CLK);
      A_SEED = 16'd6;
      B_SEED = 16'd2;
      START  = 1'b1;
      @(posedge CLK);
      for (int e = 0; e <= 75; e++) begin
         @(negedge CLK);
         if (e == 40) START = 1'b0;
         if (e <= 33) op1 = (e / 2 > 15) ? 15 : e / 2;
         else op1 = ((e - 34) / 2 > 15) ? 15 : (e - 34) / 2;
         checks++;
         if (d1_fun !== 4'(op1) || d1_done !== (e == 33 || e == 67))
            $display("FAIL b2b e=%0d got fun=%0d done=%b want fun=%0d done=%b",
                     e, d1_fun, d1_done, op1, e == 33 || e == 67);
         else passes++;
         checks++;
         if (d2_done !== (e == 49))
            $display("FAIL b2b2 e=%0d got done=%b want %b", e, d2_done, e == 49);
         else passes++;
      end
      checks++;
      if (d1_busy !== 1'b0 || d1_pass !== 1'b1)
         $display("FAIL b2b_end got busy=%b pass=%b want 0 1", d1_busy, d1_pass);
      else passes++;
   endtask

   task automatic test_random();
      logic [15:0] a, b;
      int          nf, op;
      for (int i = 0; i < 6; i++) begin
         clear_faults();
         a = 16'($urandom);
         b = (i % 3 == 0) ? 16'd0 : 16'($urandom);
         nf = $urandom_range(0, 3);
         for (int k = 0; k < nf; k++) begin
            op = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) res_x[op] = 16'($urandom_range(1, 65535));
            else flg_x[op] = 4'($urandom_range(1, 15));
         end
         do_run(a, b, (i % 2 == 0) ? -1 : int'($urandom_range(1, 30)));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mul_fault();
      test_flag_fault();
      test_div_zero();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
